pio_cmd_responder: RTL and testbench



---
 rtl/pio_cmd_responder.sv | 190 +++++++++++++++++++
 tb/tb_pio_cmd_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_responder.sv
// HPS parallel-I/O mailbox responder: decodes a toggle-handshaked command word,
// executes it against a small scratch register file, the switches and the LEDs.
module pio_cmd_responder #(
   parameter int NREGS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pp_out,
   output logic [31:0] pp_in,
   input  logic [9:0]  sw,
   output logic [8:0]  led
);

   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_e;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_WR    = 3'd1,
      OP_RD    = 3'd2,
      OP_SW    = 3'd3,
      OP_ADD   = 3'd4,
      OP_DELAY = 3'd5,
      OP_LED   = 3'd6,
      OP_ILL   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_OK       = 2'b00,
      ST_BAD_OP   = 2'b01,
      ST_BAD_ADDR = 2'b10
   } status_e;

   state_e        state_q, state_d;
   logic [31:0]   pp_out_q;
   logic          req_q, req_d;
   op_e           op_q, op_d;
   logic [3:0]    addr_q, addr_d;
   logic [23:0]   data_q, data_d;
   logic [23:0]   cnt_q, cnt_d;
   logic [23:0]   result_q, result_d;
   status_e       status_q, status_d;
   logic [31:0]   pp_in_q, pp_in_d;
   logic [8:0]    led_q, led_d;
   logic [23:0]   regs_q [NREGS];

   logic          reg_we;
   logic [23:0]   reg_wdata;
   logic [AW-1:0] reg_idx;
   logic          addr_ok;
   logic [23:0]   reg_rdata;
   logic [23:0]   reg_sum;
   op_e           new_op;

   assign reg_idx   = addr_q[AW-1:0];
   assign addr_ok   = ({28'd0, addr_q} < 32'(NREGS));
   assign reg_rdata = regs_q[reg_idx];
   assign reg_sum   = reg_rdata + data_q;
   assign new_op    = op_e'(pp_out_q[30:28]);

   // NOTE: every output of this block gets a default first, so no path through
   // the case statements can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      op_d      = op_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      status_d  = status_q;
      pp_in_d   = pp_in_q;
      led_d     = led_q;
      reg_we    = 1'b0;
      reg_wdata = '0;

      case (state_q)
         S_IDLE: begin
            if (pp_out_q[31] != pp_in_q[31]) begin
               req_d      = pp_out_q[31];
               op_d       = new_op;
               addr_d     = pp_out_q[27:24];
               data_d     = pp_out_q[23:0];
               cnt_d      = (new_op == OP_DELAY) ? pp_out_q[23:0] : 24'd0;
               pp_in_d[30] = 1'b1;
               state_d    = S_EXEC;
            end
         end

         S_EXEC: begin
            if (cnt_q != 24'd0) begin
               cnt_d = cnt_q - 24'd1;
            end else begin
               status_d = ST_OK;
               result_d = '0;
               case (op_q)
                  OP_NOP: result_d = '0;
                  OP_WR: begin
                     if (addr_ok) begin
                        reg_we    = 1'b1;
                        reg_wdata = data_q;
                        result_d  = data_q;
                     end else begin
                        status_d = ST_BAD_ADDR;
                     end
                  end
                  OP_RD: begin
                     if (addr_ok) result_d = reg_rdata;
                     else         status_d = ST_BAD_ADDR;
                  end
                  OP_SW: result_d = {14'd0, sw};
                  OP_ADD: begin
                     if (addr_ok) begin
                        reg_we    = 1'b1;
                        reg_wdata = reg_sum;
                        result_d  = reg_sum;
                     end else begin
                        status_d = ST_BAD_ADDR;
                     end
                  end
                  OP_DELAY: result_d = data_q;
                  OP_LED: begin
                     led_d    = data_q[8:0];
                     result_d = {15'd0, data_q[8:0]};
                  end
                  default: status_d = ST_BAD_OP;
               endcase
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            // All response fields, ACK included, land on the host in one edge.
            pp_in_d = {req_q, 1'b0, status_q, addr_q, result_q};
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pp_out_q <= '0;
         req_q    <= 1'b0;
         op_q     <= OP_NOP;
         addr_q   <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         status_q <= ST_OK;
         pp_in_q  <= '0;
         led_q    <= '0;
      end else begin
         state_q  <= state_d;
         pp_out_q <= pp_out;
         req_q    <= req_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         status_q <= status_d;
         pp_in_q  <= pp_in_d;
         led_q    <= led_d;
      end
   end

   // NOTE: the scratch file is small and the host relies on it reading zero
   // after an FPGA reset, so it is built from resettable flops, not a RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (reg_we) begin
         regs_q[reg_idx] <= reg_wdata;
      end
   end

   assign pp_in = pp_in_q;
   assign led   = led_q;

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Self-checking bench for pio_cmd_responder: directed vector table, corner
// sequences (mid-delay data change, reset during DELAY) and random commands.
module tb_pio_cmd_responder;

   localparam int NREGS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pp_out;
   logic [31:0] pp_in;
   logic [9:0]  sw;
   logic [8:0]  led;

   pio_cmd_responder #(.NREGS(NREGS)) dut (
      .clk    (clk),
      .reset  (reset),
      .pp_out (pp_out),
      .pp_in  (pp_in),
      .sw     (sw),
      .led    (led)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic        req;
   logic [23:0] m_regs [NREGS];
   logic [8:0]  m_led;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  addr;
      logic [23:0] data;
      logic [9:0]  swv;
      logic [1:0]  st;
      logic [23:0] res;
      logic [8:0]  led;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_led = '0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset  = 1'b1;
      pp_out = '0;
      req    = 1'b0;
      sw     = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Reference behaviour straight from the opcode table.
   task automatic model_exec(input logic [2:0] op, input logic [3:0] addr, input logic [23:0] data,
                             input logic [9:0] swv, output logic [1:0] st, output logic [23:0] res);
      int idx;
      bit ok;
      idx = int'(addr);
      ok  = idx < NREGS;
      st  = 2'b00;
      res = '0;
      case (op)
         3'd1: if (ok) begin m_regs[idx] = data; res = data; end else st = 2'b10;
         3'd2: if (ok) res = m_regs[idx]; else st = 2'b10;
         3'd3: res = {14'd0, swv};
         3'd4: if (ok) begin
                  res = 24'((int'(m_regs[idx]) + int'(data)) % (1 << 24));
                  m_regs[idx] = res;
               end else st = 2'b10;
         3'd5: res = data;
         3'd6: begin m_led = data[8:0]; res = {15'd0, data[8:0]}; end
         3'd7: st = 2'b01;
         default: res = '0;
      endcase
   endtask

   // Toggle REQ with a new command and wait for ACK, watching busy and
   // field stability while the command is in flight.
   task automatic send_cmd(input logic [2:0] op, input logic [3:0] addr, input logic [23:0] data,
                           input int alter_at, input logic [23:0] alter_data,
                           output logic [31:0] resp, output int lat, output logic hs_bad);
      logic [31:0] prev;
      @(negedge clk);
      prev   = pp_in;
      req    = ~req;
      pp_out = {req, op, addr, data};
      lat    = 0;
      hs_bad = 1'b0;
      while (1'b1) begin
         @(posedge clk);
         #1;
         lat++;
         if (pp_in[31] == req) break;
         if (pp_in[30] != (lat >= 2)) hs_bad = 1'b1;
         if ({pp_in[31], pp_in[29:0]} != {prev[31], prev[29:0]}) hs_bad = 1'b1;
         if (lat == alter_at) pp_out[23:0] = alter_data;
         if (lat >= 3000) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: actual=no ACK after %0d cycles required=ACK", lat);
            break;
         end
      end
      resp = pp_in;
   endtask

   task automatic apply(input string tag, input logic [2:0] op, input logic [3:0] addr,
                        input logic [23:0] data, input logic [9:0] swv, input logic [1:0] st,
                        input logic [23:0] res, input logic [8:0] led_exp,
                        input int alter_at, input logic [23:0] alter_data);
      logic [31:0] resp;
      int          lat;
      logic        hs_bad;
      int          exp_lat;
      sw = swv;
      exp_lat = 4 + ((op == 3'd5) ? int'(data) : 0);
      send_cmd(op, addr, data, alter_at, alter_data, resp, lat, hs_bad);
      check({tag, " resp"}, resp, {req, 1'b0, st, addr, res});
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " handshake"}, {31'd0, hs_bad}, 32'd0);
      check({tag, " led"}, {23'd0, led}, {23'd0, led_exp});
   endtask

   initial begin
      logic [2:0]  op;
      logic [3:0]  addr;
      logic [23:0] data;
      logic [9:0]  swv;
      logic [1:0]  st;
      logic [23:0] res;
      int          lat;

      vecs[0]  = '{3'd1, 4'd3,  24'h123456, 10'h000, 2'b00, 24'h123456, 9'h000};
      vecs[1]  = '{3'd2, 4'd3,  24'h000000, 10'h000, 2'b00, 24'h123456, 9'h000};
      vecs[2]  = '{3'd4, 4'd3,  24'hEDCBAB, 10'h000, 2'b00, 24'h000001, 9'h000};
      vecs[3]  = '{3'd2, 4'd3,  24'h000000, 10'h000, 2'b00, 24'h000001, 9'h000};
      vecs[4]  = '{3'd3, 4'd0,  24'h000000, 10'h2A5, 2'b00, 24'h0002A5, 9'h000};
      vecs[5]  = '{3'd6, 4'd0,  24'h0001FF, 10'h000, 2'b00, 24'h0001FF, 9'h1FF};
      vecs[6]  = '{3'd7, 4'd2,  24'h000055, 10'h000, 2'b01, 24'h000000, 9'h1FF};
      vecs[7]  = '{3'd2, 4'd3,  24'h000000, 10'h000, 2'b00, 24'h000001, 9'h1FF};
      vecs[8]  = '{3'd1, 4'd9,  24'hABCDEF, 10'h000, 2'b10, 24'h000000, 9'h1FF};
      vecs[9]  = '{3'd2, 4'd1,  24'h000000, 10'h000, 2'b00, 24'h000000, 9'h1FF};
      vecs[10] = '{3'd0, 4'd5,  24'hABCDEF, 10'h000, 2'b00, 24'h000000, 9'h1FF};
      vecs[11] = '{3'd2, 4'd9,  24'h000000, 10'h000, 2'b10, 24'h000000, 9'h1FF};
      vecs[12] = '{3'd4, 4'd15, 24'h000001, 10'h000, 2'b10, 24'h000000, 9'h1FF};
      vecs[13] = '{3'd1, 4'd7,  24'hFFFFFF, 10'h000, 2'b00, 24'hFFFFFF, 9'h1FF};
      vecs[14] = '{3'd4, 4'd7,  24'h000002, 10'h000, 2'b00, 24'h000001, 9'h1FF};
      vecs[15] = '{3'd5, 4'd0,  24'h000000, 10'h000, 2'b00, 24'h000000, 9'h1FF};
      vecs[16] = '{3'd5, 4'd6,  24'h000003, 10'h000, 2'b00, 24'h000003, 9'h1FF};
      vecs[17] = '{3'd6, 4'd4,  24'hFFFEAB, 10'h000, 2'b00, 24'h0000AB, 9'h0AB};

      reset  = 1'b1;
      pp_out = '0;
      sw     = '0;
      req    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset pp_in", pp_in, 32'd0);
      check("reset led", {23'd0, led}, 32'd0);
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < 18; i++)
         apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].swv,
               vecs[i].st, vecs[i].res, vecs[i].led, 0, 24'd0);

      // Data field rewritten while DELAY 10 is counting: latched value wins.
      apply("delay_alter", 3'd5, 4'd1, 24'd10, 10'h000, 2'b00, 24'd10, 9'h0AB, 5, 24'h000077);

      reset_dut();
      for (int i = 0; i < 150; i++) begin
         op   = 3'($urandom_range(0, 7));
         addr = 4'($urandom_range(0, 15));
         data = (op == 3'd5) ? 24'($urandom_range(0, 6)) : 24'($urandom);
         swv  = 10'($urandom);
         model_exec(op, addr, data, swv, st, res);
         apply($sformatf("rand%0d", i), op, addr, data, swv, st, res, m_led, 0, 24'd0);
      end

      // Reset in the middle of a long DELAY, REQ left high across release.
      reset_dut();
      apply("rm_led", 3'd6, 4'd0, 24'h000155, 10'h000, 2'b00, 24'h000155, 9'h155, 0, 24'd0);
      apply("rm_wr",  3'd1, 4'd3, 24'h0ABCDE, 10'h000, 2'b00, 24'h0ABCDE, 9'h155, 0, 24'd0);
      @(negedge clk);
      req    = 1'b1;
      pp_out = {1'b1, 3'd5, 4'd2, 24'd1000};
      repeat (20) @(negedge clk);
      check("rm busy", {31'd0, pp_in[30]}, 32'd1);
      reset = 1'b1;
      #1;
      check("rm pp_in in reset", pp_in, 32'd0);
      check("rm led in reset", {23'd0, led}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      lat = 0;
      while (1'b1) begin
         @(posedge clk);
         #1;
         lat++;
         if (pp_in[31] == 1'b1) break;
         if (lat >= 1500) begin
            checks++;
            failures++;
            $display("FAIL rm_ack_timeout: actual=no ACK after %0d cycles required=ACK", lat);
            break;
         end
      end
      check("rm latency", lat, 32'd1004);
      check("rm resp", pp_in, {1'b1, 1'b0, 2'b00, 4'd2, 24'd1000});
      apply("rm_rd", 3'd2, 4'd3, 24'd0, 10'h000, 2'b00, 24'd0, 9'h000, 0, 24'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
